hazard_ctrl: RTL and testbench

//  Hazard tracking and pipeline control feeding the forwarding unit. Maintains shadow ID/EX, EX/MEM and
//  MEM/WB copies of register names and control bits, and detects load-to-use hazards. Also handles

---
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Load-use hazard detection and pipeline control with shadow ID/EX, EX/MEM, MEM/WB
// register-name copies for the forwarding unit, taken-branch flush and HLT drain.
module hazard_ctrl #(
    parameter int         CNT_W  = 16,
    parameter logic [3:0] LW_OP  = 4'b1000,
    parameter logic [3:0] SW_OP  = 4'b1001,
    parameter logic [3:0] HLT_OP = 4'b1111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_id_valid,
    input  logic [3:0]       if_id_opcode,
    input  logic [3:0]       if_id_rs,
    input  logic [3:0]       if_id_rt,
    input  logic [3:0]       if_id_rd,
    input  logic             branch_taken,
    output logic [3:0]       id_ex_rs,
    output logic [3:0]       id_ex_rt,
    output logic [3:0]       id_ex_rd,
    output logic [3:0]       id_ex_opcode,
    output logic             id_ex_valid,
    output logic             id_ex_regWrite,
    output logic             id_ex_memRead,
    output logic             id_ex_memWrite,
    output logic [3:0]       ex_mem_rt,
    output logic [3:0]       ex_mem_rd,
    output logic [3:0]       ex_mem_opcode,
    output logic             ex_mem_valid,
    output logic             ex_mem_regWrite,
    output logic             ex_mem_memWrite,
    output logic [3:0]       mem_wb_rd,
    output logic [3:0]       mem_wb_opcode,
    output logic             mem_wb_valid,
    output logic             mem_wb_regWrite,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;

    logic [1:0] state, state_nxt;
    logic       dec_regWrite, dec_memRead, dec_memWrite;
    logic       load_use, hold;

    always_comb begin
        dec_regWrite = if_id_valid & (~if_id_opcode[3] |
                       (if_id_opcode inside {4'b1000, 4'b1010, 4'b1011, 4'b1110}));
        dec_memRead  = if_id_valid & (if_id_opcode == LW_OP);
        dec_memWrite = if_id_valid & (if_id_opcode == SW_OP);
    end

    // A store's rt is its data, which MEM-MEM forwarding covers, so it does not stall.
    assign load_use = id_ex_memRead & (id_ex_rd != 4'd0) & if_id_valid &
                      ((id_ex_rd == if_id_rs) | ((id_ex_rd == if_id_rt) & (if_id_opcode != SW_OP)));

    assign hold        = load_use | (state != RUN);
    assign stall_pc    = hold;
    assign stall_if_id = hold;
    assign flush_if_id = (branch_taken & ~load_use) | (state == DRAIN);

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (if_id_valid && if_id_opcode == HLT_OP && !load_use && !branch_taken)
                         state_nxt = DRAIN;
            DRAIN:   if (mem_wb_valid && mem_wb_opcode == HLT_OP)
                         state_nxt = HALT;
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RUN;
            halted          <= 1'b0;
            stall_cnt       <= '0;
            id_ex_rs        <= 4'd0;
            id_ex_rt        <= 4'd0;
            id_ex_rd        <= 4'd0;
            id_ex_opcode    <= 4'd0;
            id_ex_valid     <= 1'b0;
            id_ex_regWrite  <= 1'b0;
            id_ex_memRead   <= 1'b0;
            id_ex_memWrite  <= 1'b0;
            ex_mem_rt       <= 4'd0;
            ex_mem_rd       <= 4'd0;
            ex_mem_opcode   <= 4'd0;
            ex_mem_valid    <= 1'b0;
            ex_mem_regWrite <= 1'b0;
            ex_mem_memWrite <= 1'b0;
            mem_wb_rd       <= 4'd0;
            mem_wb_opcode   <= 4'd0;
            mem_wb_valid    <= 1'b0;
            mem_wb_regWrite <= 1'b0;
        end else begin
            state  <= state_nxt;
            halted <= (state_nxt == HALT);
            if (load_use && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);

            // Downstream stages never back-pressure.
            ex_mem_rt       <= id_ex_rt;
            ex_mem_rd       <= id_ex_rd;
            ex_mem_opcode   <= id_ex_opcode;
            ex_mem_valid    <= id_ex_valid;
            ex_mem_regWrite <= id_ex_regWrite;
            ex_mem_memWrite <= id_ex_memWrite;
            mem_wb_rd       <= ex_mem_rd;
            mem_wb_opcode   <= ex_mem_opcode;
            mem_wb_valid    <= ex_mem_valid;
            mem_wb_regWrite <= ex_mem_regWrite;

            if (hold) begin
                id_ex_rs       <= 4'd0;
                id_ex_rt       <= 4'd0;
                id_ex_rd       <= 4'd0;
                id_ex_opcode   <= 4'd0;
                id_ex_valid    <= 1'b0;
                id_ex_regWrite <= 1'b0;
                id_ex_memRead  <= 1'b0;
                id_ex_memWrite <= 1'b0;
            end else begin
                id_ex_rs       <= if_id_rs;
                id_ex_rt       <= if_id_rt;
                id_ex_rd       <= if_id_rd;
                id_ex_opcode   <= if_id_opcode;
                id_ex_valid    <= if_id_valid;
                id_ex_regWrite <= dec_regWrite;
                id_ex_memRead  <= dec_memRead;
                id_ex_memWrite <= dec_memWrite;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Random and directed stimulus for hazard_ctrl, checked every cycle against a
// stage-array model of the pipeline plus a few literal expectations.
module tb_hazard_ctrl;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_id_valid, branch_taken;
    logic [3:0]    if_id_opcode, if_id_rs, if_id_rt, if_id_rd;
    logic [3:0]    id_ex_rs, id_ex_rt, id_ex_rd, id_ex_opcode;
    logic          id_ex_valid, id_ex_regWrite, id_ex_memRead, id_ex_memWrite;
    logic [3:0]    ex_mem_rt, ex_mem_rd, ex_mem_opcode;
    logic          ex_mem_valid, ex_mem_regWrite, ex_mem_memWrite;
    logic [3:0]    mem_wb_rd, mem_wb_opcode;
    logic          mem_wb_valid, mem_wb_regWrite;
    logic          stall_pc, stall_if_id, flush_if_id, halted;
    logic [CW-1:0] stall_cnt;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .if_id_valid(if_id_valid), .if_id_opcode(if_id_opcode),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_rd(if_id_rd),
        .branch_taken(branch_taken),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd), .id_ex_opcode(id_ex_opcode),
        .id_ex_valid(id_ex_valid), .id_ex_regWrite(id_ex_regWrite),
        .id_ex_memRead(id_ex_memRead), .id_ex_memWrite(id_ex_memWrite),
        .ex_mem_rt(ex_mem_rt), .ex_mem_rd(ex_mem_rd), .ex_mem_opcode(ex_mem_opcode),
        .ex_mem_valid(ex_mem_valid), .ex_mem_regWrite(ex_mem_regWrite), .ex_mem_memWrite(ex_mem_memWrite),
        .mem_wb_rd(mem_wb_rd), .mem_wb_opcode(mem_wb_opcode),
        .mem_wb_valid(mem_wb_valid), .mem_wb_regWrite(mem_wb_regWrite),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v, rw, mr, mw;
        bit [3:0] op, rs, rt, rd;
    } stg_t;

    // st[0]=ID/EX, st[1]=EX/MEM, st[2]=MEM/WB; mstate 0 run, 1 drain, 2 halt
    stg_t st[3];
    int   mstate;
    int   mcnt;
    bit   mhalted;
    int   checks = 0;
    int   errors = 0;
    int   halt_age = 0;

    // bit n set when opcode n writes a register
    localparam bit [15:0] RW_SET = 16'h4DFF;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_load_use();
        return st[0].mr && st[0].rd != 0 && if_id_valid &&
               (st[0].rd == if_id_rs || (st[0].rd == if_id_rt && if_id_opcode != 4'h9));
    endfunction

    task automatic check_all();
        bit lu;
        lu = m_load_use();
        chk("stall_pc", stall_pc, lu || mstate != 0);
        chk("stall_if_id", stall_if_id, lu || mstate != 0);
        chk("flush_if_id", flush_if_id, (branch_taken && !lu) || mstate == 1);
        chk("halted", halted, mhalted);
        chk("stall_cnt", stall_cnt, mcnt);
        chk("id_ex", {id_ex_rs, id_ex_rt, id_ex_rd, id_ex_opcode},
            {st[0].rs, st[0].rt, st[0].rd, st[0].op});
        chk("id_ex_ctl", {id_ex_valid, id_ex_regWrite, id_ex_memRead, id_ex_memWrite},
            {st[0].v, st[0].rw, st[0].mr, st[0].mw});
        chk("ex_mem", {ex_mem_rt, ex_mem_rd, ex_mem_opcode, 1'b0, ex_mem_valid, ex_mem_regWrite, ex_mem_memWrite},
            {st[1].rt, st[1].rd, st[1].op, 1'b0, st[1].v, st[1].rw, st[1].mw});
        chk("mem_wb", {mem_wb_rd, mem_wb_opcode, 2'b0, mem_wb_valid, mem_wb_regWrite},
            {st[2].rd, st[2].op, 2'b0, st[2].v, st[2].rw});
    endtask

    task automatic model_edge();
        bit   lu, drain_done;
        stg_t nx;
        lu = m_load_use();
        drain_done = st[2].v && st[2].op == 4'hF;
        nx = '{default: 0};
        if (rst) begin
            st[0] = nx; st[1] = nx; st[2] = nx;
            mstate = 0; mcnt = 0; mhalted = 0;
            return;
        end
        if (!(lu || mstate != 0)) begin
            nx.v  = if_id_valid;
            nx.op = if_id_opcode; nx.rs = if_id_rs; nx.rt = if_id_rt; nx.rd = if_id_rd;
            nx.rw = if_id_valid && RW_SET[if_id_opcode];
            nx.mr = if_id_valid && if_id_opcode == 4'h8;
            nx.mw = if_id_valid && if_id_opcode == 4'h9;
        end
        st[2] = st[1]; st[1] = st[0]; st[0] = nx;
        if (mstate == 0 && if_id_valid && if_id_opcode == 4'hF && !lu && !branch_taken) mstate = 1;
        else if (mstate == 1 && drain_done) mstate = 2;
        mhalted = (mstate == 2);
        if (lu && mcnt < (1 << CW) - 1) mcnt++;
    endtask

    task automatic drive(input bit r, input bit v, input bit [3:0] op, input bit [3:0] rs,
                         input bit [3:0] rt, input bit [3:0] rd, input bit br);
        rst = r; if_id_valid = v; if_id_opcode = op;
        if_id_rs = rs; if_id_rt = rt; if_id_rd = rd; branch_taken = br;
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        st[0] = '{default: 0}; st[1] = '{default: 0}; st[2] = '{default: 0};
        mstate = 0; mcnt = 0; mhalted = 0;
        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); model_edge(); #1;
        tick();
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_halted", halted, 0);
        chk("rst_idex_v", id_ex_valid, 0);

        // LW r3 then dependent ADD r4,r3,r5
        drive(0, 1, 4'h8, 1, 0, 3, 0); tick();
        drive(0, 1, 4'h0, 3, 5, 4, 0); #1;
        chk("t1_stall", stall_pc, 1);
        tick();
        chk("t1_bubble", id_ex_valid, 0);
        chk("t1_cnt", stall_cnt, 1);
        #1; chk("t1_release", stall_pc, 0);
        tick();
        chk("t1_add_in", {id_ex_valid, id_ex_rd}, {1'b1, 4'd4});

        // SW with rt on LW dest goes to forwarding, not stall
        drive(0, 1, 4'h8, 1, 0, 3, 0); tick();
        drive(0, 1, 4'h9, 2, 3, 0, 0); #1;
        chk("t2_nostall", stall_pc, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        chk("t2_memwrite", ex_mem_memWrite, 1);
        chk("t2_wb_rd", mem_wb_rd, 3);

        // r0 never hazards; branch flush suppressed while stalled
        drive(0, 1, 4'h8, 1, 0, 0, 0); tick();
        drive(0, 1, 4'h0, 0, 0, 2, 1); #1;
        chk("t3_r0", stall_pc, 0);
        chk("t3_flush", flush_if_id, 1);
        drive(0, 1, 4'h8, 1, 0, 3, 0); tick();
        drive(0, 1, 4'h0, 3, 1, 2, 1); #1;
        chk("t3_noflush", flush_if_id, 0);
        tick();

        // saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 4'h8, 1, 0, 3, 0); tick();
            drive(0, 1, 4'h1, 1, 3, 2, 0); tick();
        end
        chk("t5_sat", stall_cnt, 4'hF);

        // HLT drain
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 4'hF, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0); #1;
        chk("t4_drain_stall", stall_pc, 1);
        chk("t4_drain_flush", flush_if_id, 1);
        tick(); tick();
        chk("t4_wb_op", mem_wb_opcode, 4'hF);
        chk("t4_not_yet", halted, 0);
        tick();
        chk("t4_halted", halted, 1);
        tick(); tick();
        chk("t4_sticky", halted, 1);
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        chk("t4_rst", halted, 0);
        drive(0, 0, 0, 0, 0, 0, 0); #1;
        chk("t4_run", stall_pc, 0);

        // reset with LW in ID/EX and a consumer in IF/ID
        drive(0, 1, 4'h8, 1, 0, 3, 0); tick();
        drive(1, 1, 4'h0, 3, 3, 4, 0); tick();
        chk("t6_idex", {id_ex_valid, id_ex_memRead, id_ex_rd}, 0);
        chk("t6_cnt", stall_cnt, 0);
        drive(0, 1, 4'h0, 3, 3, 4, 0); #1;
        chk("t6_nostall", stall_pc, 0);

        for (int i = 0; i < 4000; i++) begin
            bit       r, v, br;
            bit [3:0] op;
            int       k;
            halt_age = (mstate == 2) ? halt_age + 1 : 0;
            r  = ($urandom_range(0, 99) == 0) || halt_age > 6;
            v  = ($urandom_range(0, 7) != 0);
            k  = $urandom_range(0, 9);
            if (k < 4)       op = 4'h8;
            else if (k == 4) op = 4'h9;
            else if (k == 5) op = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            else             op = 4'($urandom_range(0, 14));
            br = ($urandom_range(0, 4) == 0);
            drive(r, v, op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)), br);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
